led_mode_ctrl: RTL and testbench

LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

---
 rtl/led_pkg.sv | 26 ++
 rtl/led_mode_ctrl_if.sv | 26 ++
 rtl/key_debounce.sv | 47 ++++
 rtl/led_mode_ctrl.sv | 140 ++++++++++++++
 tb/tb_led_mode_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared mode encodings and brightness/PWM constants
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF         = 2'd0,
    MODE_ON          = 2'd1,
    MODE_BREATH_SLOW = 2'd2,
    MODE_BREATH_FAST = 2'd3
  } mode_t;

  localparam logic [7:0] DUTY_MAX   = 8'd255;
  localparam logic [7:0] PWM_PERIOD = 8'd255;

  // Press order: OFF -> ON -> slow breath -> fast breath -> OFF.
  function automatic mode_t next_mode(input mode_t m);
    mode_t n;
    case (m)
      MODE_OFF:         n = MODE_ON;
      MODE_ON:          n = MODE_BREATH_SLOW;
      MODE_BREATH_SLOW: n = MODE_BREATH_FAST;
      default:          n = MODE_OFF;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/led_mode_ctrl_if.sv
// rtl/led_mode_ctrl_if.sv - key/LED signal bundle shared between the controller and its driver
interface led_mode_ctrl_if;

  logic       key;
  logic       led;
  logic [1:0] mode;
  logic [7:0] duty;
  logic       key_evt;

  modport master (
    output key,
    input  led,
    input  mode,
    input  duty,
    input  key_evt
  );

  modport slave (
    input  key,
    output led,
    output mode,
    output duty,
    output key_evt
  );

endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - push-button synchronizer, debouncer and press detector
// key_in is active-low; key_evt pulses once, one cycle after the debounced level falls.
module key_debounce #(
  parameter int DEB_CYCLES = 240000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_evt
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic          deb;
  logic          deb_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      deb     <= 1'b1;
      deb_d   <= 1'b1;
      cnt     <= '0;
      key_evt <= 1'b0;
    end else begin
      sync1   <= key_in;
      sync2   <= sync1;
      deb_d   <= deb;
      key_evt <= deb_d & ~deb;
      // Any cycle agreeing with the current level restarts the stability count.
      if (sync2 != deb) begin
        if (cnt == CW'(DEB_CYCLES - 1)) begin
          deb <= sync2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/led_mode_ctrl.sv
// rtl/led_mode_ctrl.sv - press-cycled LED mode controller with breathing ramp and PWM drive
// led is active-low; breath modes ramp duty 0..255..0 as a 510-step triangle.
module led_mode_ctrl
  import led_pkg::*;
#(
  parameter int DEB_CYCLES = 240000,
  parameter int STEP_SLOW  = 47059,
  parameter int STEP_FAST  = 23529
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key,
  output logic       led,
  output logic [1:0] mode,
  output logic [7:0] duty,
  output logic       key_evt
);

  localparam int STEP_MAX = (STEP_SLOW > STEP_FAST) ? STEP_SLOW : STEP_FAST;
  localparam int SW       = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;

  mode_t         mode_q;
  mode_t         mode_d;
  logic [7:0]    duty_q;
  logic [7:0]    duty_d;
  logic          dir_up_q;
  logic          dir_up_d;
  logic [SW-1:0] step_cnt;
  logic [SW-1:0] step_d;
  logic [SW-1:0] step_last;
  logic          is_breath;
  logic          step_tick;
  logic [7:0]    pwm_cnt;
  logic          led_q;

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_key_debounce (
    .clk    (clk),
    .rst    (rst),
    .key_in (key),
    .key_evt(key_evt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= MODE_OFF;
    end else begin
      mode_q <= mode_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (key_evt) begin
      mode_d = next_mode(mode_q);
    end
  end

  always_comb begin
    is_breath = 1'b0;
    step_last = '0;
    case (mode_q)
      MODE_BREATH_SLOW: begin
        is_breath = 1'b1;
        step_last = SW'(STEP_SLOW - 1);
      end
      MODE_BREATH_FAST: begin
        is_breath = 1'b1;
        step_last = SW'(STEP_FAST - 1);
      end
      default: begin
        is_breath = 1'b0;
        step_last = '0;
      end
    endcase
    step_tick = is_breath && (step_cnt == step_last);
  end

  // A press always wins over a coincident step tick: the ramp restarts from the entry state.
  always_comb begin
    duty_d   = duty_q;
    dir_up_d = dir_up_q;
    step_d   = step_cnt;
    if (key_evt) begin
      step_d   = '0;
      dir_up_d = 1'b1;
      duty_d   = (mode_d == MODE_ON) ? DUTY_MAX : 8'd0;
    end else if (is_breath) begin
      if (step_tick) begin
        step_d = '0;
        if (dir_up_q) begin
          if (duty_q == DUTY_MAX) begin
            dir_up_d = 1'b0;
            duty_d   = DUTY_MAX - 8'd1;
          end else begin
            duty_d = duty_q + 8'd1;
          end
        end else begin
          if (duty_q == 8'd0) begin
            dir_up_d = 1'b1;
            duty_d   = 8'd1;
          end else begin
            duty_d = duty_q - 8'd1;
          end
        end
      end else begin
        step_d = step_cnt + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      duty_q   <= 8'd0;
      dir_up_q <= 1'b1;
      step_cnt <= '0;
    end else begin
      duty_q   <= duty_d;
      dir_up_q <= dir_up_d;
      step_cnt <= step_d;
    end
  end

  // Period of 255 lets duty 255 hold the LED lit on every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt <= 8'd0;
      led_q   <= 1'b1;
    end else begin
      pwm_cnt <= (pwm_cnt == PWM_PERIOD - 8'd1) ? 8'd0 : pwm_cnt + 8'd1;
      led_q   <= (pwm_cnt < duty_q) ? 1'b0 : 1'b1;
    end
  end

  assign led  = led_q;
  assign mode = mode_q;
  assign duty = duty_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb/tb_led_mode_ctrl.sv - self-checking bench for led_mode_ctrl with a behavioural reference model
module tb_led_mode_ctrl;

  localparam int DEB = 4;
  localparam int SS  = 4;
  localparam int SF  = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   evt_cnt  = 0;

  led_mode_ctrl_if bus ();

  always #5 clk = ~clk;

  led_mode_ctrl #(
    .DEB_CYCLES(DEB),
    .STEP_SLOW (SS),
    .STEP_FAST (SF)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .key    (bus.key),
    .led    (bus.led),
    .mode   (bus.mode),
    .duty   (bus.duty),
    .key_evt(bus.key_evt)
  );

  // Reference model: key history window, elapsed-cycle triangle and modular PWM index.
  logic [15:0] hist;
  logic        m_deb;
  logic        m_fell;
  logic        m_evt;
  logic        m_led;
  int          m_mode;
  int          m_n;
  int          m_t;

  function automatic int tri_wave(input int k);
    int p;
    p = k % 510;
    return (p <= 255) ? p : 510 - p;
  endfunction

  function automatic int model_duty(input int md, input int n);
    case (md)
      0:       return 0;
      1:       return 255;
      2:       return tri_wave(n / SS);
      default: return tri_wave(n / SF);
    endcase
  endfunction

  function automatic logic next_deb(input logic [15:0] h, input logic d);
    for (int i = 1; i <= DEB; i++) begin
      if (h[i] == d) return d;
    end
    return ~d;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist   <= '1;
      m_deb  <= 1'b1;
      m_fell <= 1'b0;
      m_evt  <= 1'b0;
      m_led  <= 1'b1;
      m_mode <= 0;
      m_n    <= 0;
      m_t    <= 0;
    end else begin
      m_fell <= m_deb && !next_deb(hist, m_deb);
      m_deb  <= next_deb(hist, m_deb);
      hist   <= {hist[14:0], bus.key};
      m_evt  <= m_fell;
      m_mode <= m_evt ? (m_mode + 1) % 4 : m_mode;
      m_n    <= m_evt ? 0 : m_n + 1;
      m_t    <= m_t + 1;
      m_led  <= ((m_t % 255) < model_duty(m_mode, m_n)) ? 1'b0 : 1'b1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("model_mode", int'(bus.mode), m_mode);
    check("model_duty", int'(bus.duty), model_duty(m_mode, m_n));
    check("model_led", int'(bus.led), int'(m_led));
    check("model_key_evt", int'(bus.key_evt), int'(m_evt));
    if (bus.key_evt) evt_cnt++;
  endtask

  task automatic press();
    bus.key = 1'b0;
    repeat (12) tick();
    bus.key = 1'b1;
    repeat (12) tick();
  endtask

  task automatic wait_mode(input int target);
    int n;
    n = 0;
    while (int'(bus.mode) != target && n < 40) begin
      tick();
      n++;
    end
    check("wait_mode", int'(bus.mode), target);
  endtask

  initial begin
    int base;
    int bad;
    int exp_d;
    int n;

    bus.key = 1'b1;
    repeat (3) tick();
    check("rst_mode", int'(bus.mode), 0);
    check("rst_duty", int'(bus.duty), 0);
    check("rst_led", int'(bus.led), 1);
    check("rst_key_evt", int'(bus.key_evt), 0);
    rst = 1'b1;
    repeat (5) tick();

    // Bounce: 2-cycle toggles never satisfy the stability window.
    base = evt_cnt;
    for (int i = 0; i < 10; i++) begin
      bus.key = i[0];
      repeat (2) tick();
    end
    bus.key = 1'b0;
    repeat (10) tick();
    bus.key = 1'b1;
    repeat (12) tick();
    check("bounce_evts", evt_cnt - base, 1);
    check("bounce_mode", int'(bus.mode), 1);

    press();
    check("wrap_mode2", int'(bus.mode), 2);
    press();
    check("wrap_mode3", int'(bus.mode), 3);
    press();
    check("wrap_mode0", int'(bus.mode), 0);
    check("off_duty", int'(bus.duty), 0);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (bus.led !== 1'b1) bad++;
    end
    check("led_off_run", bad, 0);

    press();
    check("on_mode", int'(bus.mode), 1);
    check("on_duty", int'(bus.duty), 255);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (bus.led !== 1'b0) bad++;
    end
    check("led_on_run", bad, 0);

    // Slow breath: duty at n cycles after entry is tri(n/4).
    bus.key = 1'b0;
    wait_mode(2);
    check("slow_entry_duty", int'(bus.duty), 0);
    bus.key = 1'b1;
    for (int i = 1; i <= 2044; i++) begin
      tick();
      case (i)
        4:       exp_d = 1;
        1016:    exp_d = 254;
        1020:    exp_d = 255;
        1024:    exp_d = 254;
        2036:    exp_d = 1;
        2040:    exp_d = 0;
        2044:    exp_d = 1;
        default: exp_d = -1;
      endcase
      if (exp_d >= 0) check("slow_ramp", int'(bus.duty), exp_d);
    end

    // Sweep press phase against the 4-cycle step so one press lands on a tick.
    for (int d = 0; d < 4; d++) begin
      repeat (d) tick();
      bus.key = 1'b0;
      wait_mode(3);
      check("coll_duty0", int'(bus.duty), 0);
      tick();
      check("coll_duty1", int'(bus.duty), 1);
      bus.key = 1'b1;
      repeat (12) tick();
      press();
      press();
      press();
      check("coll_back_mode2", int'(bus.mode), 2);
    end

    bus.key = 1'b0;
    wait_mode(3);
    bus.key = 1'b1;
    n = 0;
    while (int'(bus.duty) != 200 && n < 1000) begin
      tick();
      n++;
    end
    check("reach_duty200", int'(bus.duty), 200);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_mode", int'(bus.mode), 0);
    check("async_rst_duty", int'(bus.duty), 0);
    check("async_rst_led", int'(bus.led), 1);
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();
    press();
    check("post_rst_mode", int'(bus.mode), 1);

    for (int r = 0; r < 250; r++) begin
      bus.key = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 12)) tick();
    end
    bus.key = 1'b1;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
